// File: rtl/fpu_result_arbiter_if.sv
// fpu_result_arbiter_if: unit-side request/grant, result-mux and downstream result handshake signals
interface fpu_result_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 5
);
  logic [3:0]          unit_valid;
  logic [4*FLAG_W-1:0] unit_flags;
  logic [3:0]          unit_ready;
  logic [1:0]          Sel;
  logic [DATA_W-1:0]   mux_out;
  logic                res_valid;
  logic                res_ready;
  logic [DATA_W-1:0]   res_data;
  logic [FLAG_W-1:0]   res_flags;
  logic [1:0]          res_src;
  modport master (
    input  unit_valid, unit_flags, mux_out, res_ready,
    output unit_ready, Sel, res_valid, res_data, res_flags, res_src
  );
  modport slave (
    output unit_valid, unit_flags, mux_out, res_ready,
    input  unit_ready, Sel, res_valid, res_data, res_flags, res_src
  );
endinterface

// File: rtl/fpu_result_arbiter.sv
// fpu_result_arbiter: round-robin grant over four FU results, drives mux select, 2-entry output buffer
module fpu_result_arbiter #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 5,
  parameter int DEPTH  = 2
) (
  input logic clk,
  input logic rst_n,
  fpu_result_arbiter_if.master bus
);
  logic [1:0]        ptr, sel_q, gnt, idx, count;
  logic              gnt_ok, space, pop, wr_ptr, rd_ptr;
  logic [FLAG_W-1:0] gnt_flags;
  logic [DATA_W-1:0] data_q  [2];
  logic [FLAG_W-1:0] flags_q [2];
  logic [1:0]        src_q   [2];
  // space ignores res_ready so there is no res_ready -> unit_ready path; held off during reset
  assign space = rst_n && (count < 2'(DEPTH));
  always_comb begin
    gnt_ok = 1'b0;
    gnt = ptr;
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (space && bus.unit_valid[idx]) begin
        gnt_ok = 1'b1;
        gnt = idx;
      end
    end
  end
  assign gnt_flags      = bus.unit_flags[32'(gnt)*FLAG_W +: FLAG_W];
  assign bus.unit_ready = gnt_ok ? 4'b0001 << gnt : 4'b0000;
  assign bus.Sel        = gnt_ok ? gnt : sel_q;
  assign bus.res_valid  = count != 2'd0;
  assign bus.res_data   = bus.res_valid ? data_q[rd_ptr] : '0;
  assign bus.res_flags  = bus.res_valid ? flags_q[rd_ptr] : '0;
  assign bus.res_src    = bus.res_valid ? src_q[rd_ptr] : 2'd0;
  assign pop            = bus.res_valid && bus.res_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= 2'd0;
      sel_q  <= 2'd0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (gnt_ok) begin
        ptr    <= gnt + 2'd1;
        sel_q  <= gnt;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(gnt_ok) - 2'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (gnt_ok) begin
      data_q[wr_ptr]  <= bus.mux_out;
      flags_q[wr_ptr] <= gnt_flags;
      src_q[wr_ptr]   <= gnt;
    end
  end
endmodule
